// File: rtl/memory_arbiter_if.sv
`default_nettype none
// ============================================================================
// memory_arbiter_if
// Requester and Memory-side bus of the unified-memory arbiter.
// Revision: 1.0
// ============================================================================
interface memory_arbiter_if #(
    parameter int WORD     = 8,
    parameter int ADDRESSL = 5
);
    logic                fetchReq;
    logic [ADDRESSL-1:0] fetchAddr;
    logic                fetchAck;
    logic [WORD-1:0]     fetchData;
    logic                dataReq;
    logic                dataWe;
    logic [ADDRESSL-1:0] dataAddr;
    logic [WORD-1:0]     dataWData;
    logic                dataAck;
    logic [WORD-1:0]     dataRData;
    logic [ADDRESSL-1:0] address;
    logic [WORD-1:0]     writeData;
    logic                memRead;
    logic                memWrite;
    logic [WORD-1:0]     readData;
    logic                busy;

    // slave: the arbiter; master: the requesters plus the Memory around it
    modport slave (
        input  fetchReq, fetchAddr, dataReq, dataWe, dataAddr, dataWData, readData,
        output fetchAck, fetchData, dataAck, dataRData,
               address, writeData, memRead, memWrite, busy
    );

    modport master (
        output fetchReq, fetchAddr, dataReq, dataWe, dataAddr, dataWData, readData,
        input  fetchAck, fetchData, dataAck, dataRData,
               address, writeData, memRead, memWrite, busy
    );
endinterface
`default_nettype wire

// File: rtl/memory_arbiter.sv
`default_nettype none
// ============================================================================
// memory_arbiter
// Round-robin sharing of a single-port Memory between fetch and data ports,
// using a fixed 3-cycle IDLE/ACCESS/RESPOND transaction.
// Revision: 1.0
// ============================================================================
module memory_arbiter #(
    parameter int WORD     = 8,
    parameter int ADDRESSL = 5
) (
    input  logic             clk,
    input  logic             rst,
    memory_arbiter_if.slave  bus
);
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ACCESS  = 2'd1,
        RESPOND = 2'd2
    } state_t;

    localparam logic PORT_FETCH = 1'b0;
    localparam logic PORT_DATA  = 1'b1;

    state_t              state_q, state_d;
    logic                last_grant_q, last_grant_d;
    logic                grant_q, grant_d;
    logic [ADDRESSL-1:0] address_q, address_d;
    logic [WORD-1:0]     write_data_q, write_data_d;
    logic                mem_read_q, mem_read_d;
    logic                mem_write_q, mem_write_d;
    logic                fetch_ack_q, fetch_ack_d;
    logic                data_ack_q, data_ack_d;
    logic [WORD-1:0]     fetch_data_q, fetch_data_d;
    logic [WORD-1:0]     data_rdata_q, data_rdata_d;
    logic                pick;

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        grant_d      = grant_q;
        address_d    = address_q;
        write_data_d = write_data_q;
        mem_read_d   = 1'b0;
        mem_write_d  = 1'b0;
        fetch_ack_d  = 1'b0;
        data_ack_d   = 1'b0;
        fetch_data_d = fetch_data_q;
        data_rdata_d = data_rdata_q;
        pick         = PORT_FETCH;

        case (state_q)
            IDLE: begin
                if (bus.fetchReq || bus.dataReq) begin
                    // On a tie the port that did not win last time goes next
                    if (bus.fetchReq && bus.dataReq) begin
                        pick = ~last_grant_q;
                    end else begin
                        pick = bus.dataReq ? PORT_DATA : PORT_FETCH;
                    end
                    grant_d      = pick;
                    last_grant_d = pick;
                    if (pick == PORT_DATA) begin
                        address_d   = bus.dataAddr;
                        mem_read_d  = ~bus.dataWe;
                        mem_write_d = bus.dataWe;
                        if (bus.dataWe) begin
                            write_data_d = bus.dataWData;
                        end
                    end else begin
                        address_d  = bus.fetchAddr;
                        mem_read_d = 1'b1;
                    end
                    state_d = ACCESS;
                end
            end
            ACCESS: begin
                // mem_read_q marks a read access; stores leave read data alone
                if (mem_read_q) begin
                    if (grant_q == PORT_FETCH) begin
                        fetch_data_d = bus.readData;
                    end else begin
                        data_rdata_d = bus.readData;
                    end
                end
                fetch_ack_d = (grant_q == PORT_FETCH);
                data_ack_d  = (grant_q == PORT_DATA);
                state_d     = RESPOND;
            end
            RESPOND: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= IDLE;
            last_grant_q <= PORT_DATA;
            grant_q      <= PORT_FETCH;
            address_q    <= '0;
            write_data_q <= '0;
            mem_read_q   <= 1'b0;
            mem_write_q  <= 1'b0;
            fetch_ack_q  <= 1'b0;
            data_ack_q   <= 1'b0;
            fetch_data_q <= '0;
            data_rdata_q <= '0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            grant_q      <= grant_d;
            address_q    <= address_d;
            write_data_q <= write_data_d;
            mem_read_q   <= mem_read_d;
            mem_write_q  <= mem_write_d;
            fetch_ack_q  <= fetch_ack_d;
            data_ack_q   <= data_ack_d;
            fetch_data_q <= fetch_data_d;
            data_rdata_q <= data_rdata_d;
        end
    end

    assign bus.address   = address_q;
    assign bus.writeData = write_data_q;
    assign bus.memRead   = mem_read_q;
    assign bus.memWrite  = mem_write_q;
    assign bus.fetchAck  = fetch_ack_q;
    assign bus.dataAck   = data_ack_q;
    assign bus.fetchData = fetch_data_q;
    assign bus.dataRData = data_rdata_q;
    assign bus.busy      = (state_q != IDLE);

endmodule
`default_nettype wire
